regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port register file for the CPU datapath. It provides NUM_RD registered read ports and NUM_WR write ports. Every register clears on reset. Same-cycle write-to-read bypass lets a read return the value being written that cycle. Per-port read enables hold read data while the pipeline stalls.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 2, number of write ports (1..2)
BYPASS, 1, 1 = write data forwarded to same-cycle reads; 0 = reads return the pre-write value

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
rd_en  in  NUM_RD  per-port read enable
rd_addr  in  NUM_RD*ADDR_W  read addresses, port p at bits [p*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  registered read data, port p at bits [p*DATA_W +: DATA_W]
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*ADDR_W  write addresses, packed as for rd_addr
wr_data  in  NUM_WR*DATA_W  write data, packed
wr_conflict  out  1  registered flag: a write-address collision occurred in the previous cycle

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- While rst is high:
  - all DEPTH registers = 0
  - all rd_data = 0
  - wr_conflict = 0
  - no write takes effect
- Deassertion is sampled at the next clk edge.
- Read latency is 1 cycle. If rd_en[p]=1 at edge N, rd_data[p] holds the value from edge N onward. If rd_en[p]=0, rd_data[p] holds its previous value.
- Write takes effect at the edge where wr_en[w]=1. The stored value is visible to reads sampled at later edges.
- Bypass, BYPASS=1: a read at edge N to an address written at edge N returns the new wr_data. BYPASS=0 returns the old contents.
- Write collision: if NUM_WR=2, both enables are high and the addresses are equal:
  - port 1 wins, for both storage and bypass
  - wr_conflict = 1 for one cycle
  - otherwise wr_conflict = 0
- Out-of-range addresses cannot occur, since DEPTH is a power of two.
- Simultaneous read of the same address on several ports is legal; all return identical data.
- Reset asserted mid-operation overrides any in-flight write. A write at the same edge reset rises is discarded.
- No state machine beyond the storage array and output registers. rd_data is driven only from flops.

Optional Feature:
Macro RF_ZERO_REG_EN.
- Defined: register 0 is hardwired to zero.
  - Writes to address 0 are ignored and never reported as conflicts.
  - Reads of address 0 return 0, including under bypass.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Package rf_pkg holds:
  - default constants RF_DATA_W=16, RF_ADDR_W=3
  - MAX_RD=4, MAX_WR=2
  - function rf_sel(addr, port) for packed-bus slicing
- One sub-module, rf_read_port: a single read port, instantiated NUM_RD times via generate.
  - It contains the bypass/priority mux and the rd_data output register with enable.
  - Inputs: array contents, write ports, BYPASS.

Test Plan:
- Reset: write 0xBEEF to r5, assert rst, then read r5 -> rd_data = 0x0000; rd_data = 0 while rst is high.
- Basic write/read: write r3 = 0x1234, then at the next edge read r3 on port 0 and r3 on port 1 -> both ports return 0x1234 after 1 cycle.
- Bypass: write r2 = 0xA5A5 and read r2 in the same cycle (old value 0x0001):
  - BYPASS=1 -> 0xA5A5
  - BYPASS=0 -> 0x0001
- Conflict: wr_en = 2'b11, both addresses r6, data 0x1111 on port 0 and 0x2222 on port 1 -> r6 = 0x2222 and wr_conflict pulses 1 for exactly one cycle.
- Stall hold: rd_en[0]=1 on r1 (0x00FF), then rd_en[0]=0 while r1 is rewritten to 0x0F0F -> rd_data[0] stays 0x00FF until rd_en returns.
- Zero register with RF_ZERO_REG_EN defined: write r0 = 0xFFFF with a same-cycle read -> returns 0; a later read of r0 also returns 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and packed-bus slicing helper for the multi-port register file.
package rf_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 3;
  localparam int MAX_RD    = 4;
  localparam int MAX_WR    = 2;

  // LSB position of lane `port` in a packed bus whose lanes are `lane_w` bits wide.
  function automatic int rf_sel(input int lane_w, input int port);
    return lane_w * port;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: write-bypass/priority mux feeding an enabled output flop.
// Latency 1 cycle; rd_en low holds rd_data (stall). Build option: RF_ZERO_REG_EN.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               rd_en,
  input  logic [ADDR_W-1:0]                  rd_addr,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] mem,
  input  logic [NUM_WR-1:0]                  wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]           wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]           wr_data,
  output logic [DATA_W-1:0]                  rd_data
);

  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_val;
  logic [DATA_W-1:0] rd_next;

  // Later write ports override earlier ones, so port 1 wins a collision.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_val = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && (wr_addr[rf_sel(ADDR_W, w) +: ADDR_W] == rd_addr)) begin
        fwd_hit = 1'b1;
        fwd_val = wr_data[rf_sel(DATA_W, w) +: DATA_W];
      end
    end
  end

  always_comb begin
    rd_next = ((BYPASS != 0) && fwd_hit) ? fwd_val : mem[rd_addr];
`ifdef RF_ZERO_REG_EN
    if (rd_addr == '0) begin
      rd_next = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_next;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_WR write ports, NUM_RD registered read ports, port 1 wins collisions.
// Latency 1 cycle, no backpressure; RF_ZERO_REG_EN hardwires register 0 to zero.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic                     wr_conflict
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [NUM_WR-1:0]            wr_act;
  logic                         conflict_next;

  // Effective write enables; writes to a hardwired zero register are dropped here
  // so they neither store, forward nor count as collisions.
  always_comb begin
    wr_act = wr_en;
`ifdef RF_ZERO_REG_EN
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_addr[rf_sel(ADDR_W, w) +: ADDR_W] == '0) begin
        wr_act[w] = 1'b0;
      end
    end
`endif
  end

  generate
    if (NUM_WR == 2) begin : g_conflict
      assign conflict_next = wr_act[0] & wr_act[1] &
                             (wr_addr[0 +: ADDR_W] == wr_addr[ADDR_W +: ADDR_W]);
    end else begin : g_no_conflict
      assign conflict_next = 1'b0;
    end
  endgenerate

  // Ascending port order makes the last non-blocking write (port 1) the one that sticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_act[w]) begin
          mem[wr_addr[rf_sel(ADDR_W, w) +: ADDR_W]] <= wr_data[rf_sel(DATA_W, w) +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_conflict <= 1'b0;
    end else begin
      wr_conflict <= conflict_next;
    end
  end

  generate
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_WR (NUM_WR),
        .BYPASS (BYPASS)
      ) u_rd (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (rd_en[p]),
        .rd_addr (rd_addr[rf_sel(ADDR_W, p) +: ADDR_W]),
        .mem     (mem),
        .wr_en   (wr_act),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rd_data[rf_sel(DATA_W, p) +: DATA_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: BYPASS=1 and BYPASS=0 instances driven in parallel against an array model.
module tb_regfile_mp;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int DEPTH = 8;
`ifdef RF_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NR-1:0]    rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic [NR*DW-1:0] rd_data_b, rd_data_nb;
  logic             conf_b, conf_nb;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mdl_mem [DEPTH];
  logic [DW-1:0] exp_b   [NR];
  logic [DW-1:0] exp_nb  [NR];
  logic          exp_conf;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_conflict(conf_b));

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_conflict(conf_nb));

  always #5 clk = ~clk;

  function automatic bit is_zero_reg(input logic [AW-1:0] a);
    return ZERO_EN && (a == '0);
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_wr(input int w, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[w]            = en;
    wr_addr[w*AW +: AW] = a;
    wr_data[w*DW +: DW] = d;
  endtask

  task automatic set_rd(input int p, input logic en, input logic [AW-1:0] a);
    rd_en[p]            = en;
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic idle();
    rd_en = '0;
    wr_en = '0;
  endtask

  // Predict from the register-file rules, advance one clock, compare every output.
  task automatic step();
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
      for (int p = 0; p < NR; p++) begin
        exp_b[p]  = '0;
        exp_nb[p] = '0;
      end
      exp_conf = 1'b0;
    end else begin
      for (int p = 0; p < NR; p++) begin
        if (rd_en[p]) begin
          a = rd_addr[p*AW +: AW];
          v = mdl_mem[a];
          exp_nb[p] = v;
          for (int w = 0; w < NW; w++)
            if (wr_en[w] && wr_addr[w*AW +: AW] == a) v = wr_data[w*DW +: DW];
          exp_b[p] = v;
          if (is_zero_reg(a)) begin
            exp_b[p]  = '0;
            exp_nb[p] = '0;
          end
        end
      end
      exp_conf = (wr_en == 2'b11) && (wr_addr[0 +: AW] == wr_addr[AW +: AW]) &&
                 !is_zero_reg(wr_addr[0 +: AW]);
      for (int w = 0; w < NW; w++)
        if (wr_en[w] && !is_zero_reg(wr_addr[w*AW +: AW]))
          mdl_mem[wr_addr[w*AW +: AW]] = wr_data[w*DW +: DW];
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < NR; p++) begin
      check($sformatf("byp_rd%0d", p), rd_data_b[p*DW +: DW], exp_b[p]);
      check($sformatf("nobyp_rd%0d", p), rd_data_nb[p*DW +: DW], exp_nb[p]);
    end
    check("byp_conflict", DW'(conf_b), DW'(exp_conf));
    check("nobyp_conflict", DW'(conf_nb), DW'(exp_conf));
  endtask

  initial begin
    rd_en   = '0;
    rd_addr = '0;
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;

    // Reset state
    rst = 1'b1;
    step();
    check("reset_rd0", rd_data_b[0 +: DW], 16'h0000);
    check("reset_conflict", DW'(conf_b), 16'h0000);
    rst = 1'b0;
    step();

    // Reset clears stored data and read outputs asynchronously
    set_wr(0, 1'b1, 3'd5, 16'hBEEF);
    step();
    idle();
    set_rd(0, 1'b1, 3'd5);
    step();
    check("pre_reset_r5", rd_data_b[0 +: DW], 16'hBEEF);
    idle();
    rst = 1'b1;
    #1;
    check("async_reset_rd0", rd_data_b[0 +: DW], 16'h0000);
    step();
    rst = 1'b0;
    set_rd(0, 1'b1, 3'd5);
    step();
    check("after_reset_r5", rd_data_b[0 +: DW], 16'h0000);

    // Basic write then dual-port read
    idle();
    set_wr(0, 1'b1, 3'd3, 16'h1234);
    step();
    idle();
    set_rd(0, 1'b1, 3'd3);
    set_rd(1, 1'b1, 3'd3);
    step();
    check("basic_p0", rd_data_b[0 +: DW], 16'h1234);
    check("basic_p1", rd_data_b[DW +: DW], 16'h1234);

    // Same-cycle bypass vs pre-write value
    idle();
    set_wr(0, 1'b1, 3'd2, 16'h0001);
    step();
    idle();
    set_wr(1, 1'b1, 3'd2, 16'hA5A5);
    set_rd(0, 1'b1, 3'd2);
    step();
    check("bypass_on", rd_data_b[0 +: DW], 16'hA5A5);
    check("bypass_off", rd_data_nb[0 +: DW], 16'h0001);

    // Write collision: port 1 wins, one-cycle flag
    idle();
    set_wr(0, 1'b1, 3'd6, 16'h1111);
    set_wr(1, 1'b1, 3'd6, 16'h2222);
    step();
    check("conflict_set", DW'(conf_b), 16'h0001);
    idle();
    set_rd(1, 1'b1, 3'd6);
    step();
    check("conflict_clear", DW'(conf_b), 16'h0000);
    check("conflict_winner", rd_data_nb[DW +: DW], 16'h2222);

    // Stall hold
    idle();
    set_wr(0, 1'b1, 3'd1, 16'h00FF);
    step();
    idle();
    set_rd(0, 1'b1, 3'd1);
    step();
    check("stall_load", rd_data_b[0 +: DW], 16'h00FF);
    idle();
    set_rd(0, 1'b0, 3'd1);
    set_wr(1, 1'b1, 3'd1, 16'h0F0F);
    step();
    check("stall_hold1", rd_data_b[0 +: DW], 16'h00FF);
    idle();
    step();
    check("stall_hold2", rd_data_b[0 +: DW], 16'h00FF);
    set_rd(0, 1'b1, 3'd1);
    step();
    check("stall_release", rd_data_b[0 +: DW], 16'h0F0F);

    // Register 0 behaviour (hardwired zero only with RF_ZERO_REG_EN)
    idle();
    set_wr(0, 1'b1, 3'd0, 16'hFFFF);
    set_rd(0, 1'b1, 3'd0);
    step();
    check("r0_bypass", rd_data_b[0 +: DW], ZERO_EN ? 16'h0000 : 16'hFFFF);
    idle();
    set_rd(1, 1'b1, 3'd0);
    step();
    check("r0_later", rd_data_b[DW +: DW], ZERO_EN ? 16'h0000 : 16'hFFFF);
    idle();
    set_wr(0, 1'b1, 3'd0, 16'h1111);
    set_wr(1, 1'b1, 3'd0, 16'h2222);
    step();
    check("r0_conflict", DW'(conf_b), ZERO_EN ? 16'h0000 : 16'h0001);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 49) == 0);
      rd_en   = NR'($urandom);
      rd_addr = (NR*AW)'($urandom);
      wr_en   = NW'($urandom);
      wr_addr = (NW*AW)'($urandom);
      wr_data = (NW*DW)'($urandom);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
